// File: rtl/repeated_sub_divider.sv
// rtl/repeated_sub_divider.sv - sequential unsigned divider by repeated subtraction
//
// Purpose:
//    Divides an unsigned dividend by an unsigned divisor by subtracting the
//    divisor from a running remainder and counting the subtractions. The
//    dividend and then the divisor arrive on the shared din bus in the two
//    cycles after start is accepted. Results stay registered until the next
//    operation begins.
//
// Configuration macro:
//    DIV_DONE_PULSE_EN - defined: done is a one-cycle pulse and the FSM
//                        returns to IDLE unconditionally.
//                        undefined: done holds while start stays high and the
//                        FSM returns to IDLE at the first edge with start low.
//
// Ports:
//    clk        in   1      rising-edge clock
//    rst        in   1      synchronous active-high reset
//    start      in   1      operation request, sampled only in IDLE
//    din        in   WIDTH  dividend in LDA cycle, divisor in LDB cycle
//    busy       out  1      high in LDA, LDB, SUB
//    done       out  1      high in DONE
//    dbz        out  1      divide-by-zero flag, valid while done is high
//    quotient   out  WIDTH  registered quotient
//    remainder  out  WIDTH  registered remainder

module repeated_sub_divider #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] din,
   output logic             busy,
   output logic             done,
   output logic             dbz,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LDA  = 3'd1,
      LDB  = 3'd2,
      SUB  = 3'd3,
      DONE = 3'd4
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] divisor;
   logic             divisor_zero;
   logic             rem_ge;

   assign divisor_zero = (divisor == '0);
   assign rem_ge       = (remainder >= divisor);

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and Moore outputs
   always_comb begin
      state_next = state;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = LDA;
            end
         end
         LDA: begin
            busy       = 1'b1;
            state_next = LDB;
         end
         LDB: begin
            busy       = 1'b1;
            state_next = SUB;
         end
         SUB: begin
            busy = 1'b1;
            // A zero divisor must leave immediately, otherwise rem_ge would
            // keep the loop alive forever.
            if (divisor_zero || !rem_ge) begin
               state_next = DONE;
            end
         end
         DONE: begin
            done = 1'b1;
`ifdef DIV_DONE_PULSE_EN
            state_next = IDLE;
`else
            // Holding in DONE while start is high prevents a held start
            // from retriggering a new operation.
            if (!start) begin
               state_next = IDLE;
            end
`endif
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         quotient  <= '0;
         remainder <= '0;
         divisor   <= '0;
         dbz       <= 1'b0;
      end else begin
         case (state)
            LDA: begin
               remainder <= din;
               dbz       <= 1'b0;
            end
            LDB: begin
               divisor  <= din;
               quotient <= '0;
            end
            SUB: begin
               if (divisor_zero) begin
                  quotient <= '1;
                  dbz      <= 1'b1;
               end else if (rem_ge) begin
                  // Guarded by rem_ge, so this never underflows; the count
                  // is bounded by the dividend so it never wraps either.
                  remainder <= remainder - divisor;
                  quotient  <= quotient + WIDTH'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
